// File: rtl/band_envelope_smoother_pkg.sv
// Shared types and sizing helpers for the per-channel band magnitude smoother.
package smoother_pkg;

    typedef enum logic {
        BOXCAR   = 1'b0,
        ENVELOPE = 1'b1
    } smooth_mode_t;

    // Boxcar sum needs log2(depth) guard bits so it can never overflow.
    function automatic int sum_width(input int width, input int num_samples);
        return width + $clog2(num_samples);
    endfunction

endpackage

// File: rtl/band_envelope_smoother_if.sv
// Sample-in / smoothed-out bus of the band smoother; master drives samples, slave is the smoother.
interface band_envelope_smoother_if #(
    parameter int WIDTH = 16,
    parameter int CH_W  = 3
);
    logic             clear;
    logic             mode;
    logic [WIDTH-1:0] mag_in;
    logic [CH_W-1:0]  mag_in_ch;
    logic             mag_in_valid;
    logic [WIDTH-1:0] mag_out;
    logic [CH_W-1:0]  mag_out_ch;
    logic             mag_out_valid;

    modport master (
        output clear, mode, mag_in, mag_in_ch, mag_in_valid,
        input  mag_out, mag_out_ch, mag_out_valid
    );

    modport slave (
        input  clear, mode, mag_in, mag_in_ch, mag_in_valid,
        output mag_out, mag_out_ch, mag_out_valid
    );
endinterface

// File: rtl/band_envelope_smoother_envelope_step.sv
// Asymmetric attack/decay follower step; a nonzero gap always moves env by at least one LSB.
module envelope_step #(
    parameter int WIDTH        = 16,
    parameter int ATTACK_SHIFT = 1,
    parameter int DECAY_SHIFT  = 4
) (
    input  logic [WIDTH-1:0] in_i,
    input  logic [WIDTH-1:0] env_i,
    output logic [WIDTH-1:0] env_next_o
);
    logic             rise;
    logic             fall;
    logic [WIDTH-1:0] diff;
    logic [WIDTH-1:0] step_raw;
    logic [WIDTH-1:0] step;

    always_comb begin
        rise     = in_i > env_i;
        fall     = in_i < env_i;
        diff     = rise ? (in_i - env_i) : (env_i - in_i);
        step_raw = rise ? (diff >> ATTACK_SHIFT) : (diff >> DECAY_SHIFT);
        // Step never exceeds diff, so env lands on or short of the input and cannot wrap.
        step     = ((step_raw == '0) && (diff != '0)) ? WIDTH'(1) : step_raw;
        if (rise) begin
            env_next_o = env_i + step;
        end else if (fall) begin
            env_next_o = env_i - step;
        end else begin
            env_next_o = env_i;
        end
    end
endmodule

// File: rtl/band_envelope_smoother.sv
// Time-multiplexed per-channel magnitude smoother: boxcar average or envelope follower, latency 1.
module band_envelope_smoother
    import smoother_pkg::*;
#(
    parameter int WIDTH        = 16,
    parameter int NUM_CH       = 8,
    parameter int NUM_SAMPLES  = 8,
    parameter int ATTACK_SHIFT = 1,
    parameter int DECAY_SHIFT  = 4
) (
    input  logic                     clk,
    input  logic                     rst,
    band_envelope_smoother_if.slave  bus
);
    localparam int CH_W  = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;
    localparam int SHIFT = $clog2(NUM_SAMPLES);
    localparam int SUM_W = sum_width(WIDTH, NUM_SAMPLES);

    logic [WIDTH-1:0] hist_q [NUM_CH][NUM_SAMPLES];
    logic [SUM_W-1:0] sum_q  [NUM_CH];
    logic [WIDTH-1:0] env_q  [NUM_CH];

    logic [WIDTH-1:0] mag_out_q;
    logic [CH_W-1:0]  mag_out_ch_q;
    logic             mag_out_valid_q;

    logic             ch_ok;
    logic             accept;
    logic [CH_W-1:0]  idx;
    logic [WIDTH-1:0] hist_cur [NUM_SAMPLES];
    logic [SUM_W-1:0] sum_cur;
    logic [WIDTH-1:0] env_cur;
    logic [SUM_W-1:0] sum_d;
    logic [WIDTH-1:0] box_d;
    logic [WIDTH-1:0] env_d;

    // A clear in the same cycle as a sample makes the sample see zeroed state.
    always_comb begin
        ch_ok   = 32'(bus.mag_in_ch) < NUM_CH;
        accept  = bus.mag_in_valid && ch_ok;
        idx     = ch_ok ? bus.mag_in_ch : '0;
        for (int k = 0; k < NUM_SAMPLES; k++) begin
            hist_cur[k] = bus.clear ? '0 : hist_q[idx][k];
        end
        sum_cur = bus.clear ? '0 : sum_q[idx];
        env_cur = bus.clear ? '0 : env_q[idx];
        sum_d   = sum_cur - SUM_W'(hist_cur[NUM_SAMPLES-1]) + SUM_W'(bus.mag_in);
        box_d   = WIDTH'(sum_d >> SHIFT);
    end

    envelope_step #(
        .WIDTH        (WIDTH),
        .ATTACK_SHIFT (ATTACK_SHIFT),
        .DECAY_SHIFT  (DECAY_SHIFT)
    ) u_env_step (
        .in_i       (bus.mag_in),
        .env_i      (env_cur),
        .env_next_o (env_d)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int c = 0; c < NUM_CH; c++) begin
                for (int k = 0; k < NUM_SAMPLES; k++) begin
                    hist_q[c][k] <= '0;
                end
                sum_q[c] <= '0;
                env_q[c] <= '0;
            end
            mag_out_q       <= '0;
            mag_out_ch_q    <= '0;
            mag_out_valid_q <= 1'b0;
        end else begin
            mag_out_valid_q <= accept;
            if (bus.clear) begin
                for (int c = 0; c < NUM_CH; c++) begin
                    for (int k = 0; k < NUM_SAMPLES; k++) begin
                        hist_q[c][k] <= '0;
                    end
                    sum_q[c] <= '0;
                    env_q[c] <= '0;
                end
            end
            // Both smoothers always advance; mode only picks which one is reported.
            if (accept) begin
                hist_q[idx][0] <= bus.mag_in;
                for (int k = 1; k < NUM_SAMPLES; k++) begin
                    hist_q[idx][k] <= hist_cur[k-1];
                end
                sum_q[idx]   <= sum_d;
                env_q[idx]   <= env_d;
                mag_out_q    <= (smooth_mode_t'(bus.mode) == ENVELOPE) ? env_d : box_d;
                mag_out_ch_q <= bus.mag_in_ch;
            end
        end
    end

    assign bus.mag_out       = mag_out_q;
    assign bus.mag_out_ch    = mag_out_ch_q;
    assign bus.mag_out_valid = mag_out_valid_q;
endmodule
